// File: rtl/hack_mem_pkg.sv
// Shared types and constants for the Hack CPU memory sequencer.
// State and operation encodings are used by the sequencer and its bench.
package hack_mem_pkg;

    localparam int TIMEOUT_DEFAULT = 63;
    localparam int CNT_W           = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_STEP,
        ST_ERROR
    } seq_state_t;

    typedef enum logic [1:0] {
        OP_FETCH,
        OP_DREAD,
        OP_DWRITE
    } seq_op_t;

endpackage

// File: rtl/mem_sequencer.sv
// Sequences instruction fetch and data read/write transfers to spi_mem and
// releases the CPU for one cycle once every transfer of the instruction is done.
module mem_sequencer
    import hack_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        run_i,
    input  logic [15:0] pc_i,
    input  logic [15:0] addressM_i,
    input  logic [15:0] outM_i,
    input  logic        readM_i,
    input  logic        writeM_i,
    input  logic        halt_i,
    output logic        start_o,
    output logic        rwb_o,
    output logic        selDest_o,
    output logic [15:0] address_o,
    output logic [15:0] data_o,
    output logic        cpu_step_o,
    output logic        error_o
);

    // Count value seen in the last WAIT cycle that is still allowed to have halt_i high.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    seq_state_t       r_state;
    seq_state_t       w_nxt_state;
    seq_op_t          r_op;
    seq_op_t          w_nxt_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wr_pend;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        w_nxt_state = r_state;
        w_nxt_op    = r_op;
        case (r_state)
            ST_IDLE: begin
                if (run_i) begin
                    w_nxt_state = ST_ISSUE;
                    w_nxt_op    = OP_FETCH;
                end
            end
            ST_ISSUE: w_nxt_state = ST_WAIT;
            ST_WAIT: begin
                if (!halt_i)                w_nxt_state = ST_GAP;
                else if (r_cnt == CNT_LAST) w_nxt_state = ST_ERROR;
            end
            ST_GAP: begin
                w_nxt_state = ST_STEP;
                case (r_op)
                    OP_FETCH: begin
                        if (readM_i) begin
                            w_nxt_state = ST_ISSUE;
                            w_nxt_op    = OP_DREAD;
                        end else if (writeM_i) begin
                            w_nxt_state = ST_ISSUE;
                            w_nxt_op    = OP_DWRITE;
                        end
                    end
                    OP_DREAD: begin
                        if (r_wr_pend) begin
                            w_nxt_state = ST_ISSUE;
                            w_nxt_op    = OP_DWRITE;
                        end
                    end
                    default: w_nxt_state = ST_STEP;
                endcase
            end
            ST_STEP: begin
                if (run_i) begin
                    w_nxt_state = ST_ISSUE;
                    w_nxt_op    = OP_FETCH;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_ERROR: w_nxt_state = ST_ERROR;
            default:  w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_FETCH;
            r_cnt      <= '0;
            r_wr_pend  <= 1'b0;
            start_o    <= 1'b0;
            rwb_o      <= 1'b1;
            selDest_o  <= 1'b0;
            address_o  <= '0;
            data_o     <= '0;
            cpu_step_o <= 1'b0;
            error_o    <= 1'b0;
        end else begin
            // NOTE: non-blocking only here, so every register sees pre-edge values.
            r_state    <= w_nxt_state;
            r_op       <= w_nxt_op;
            start_o    <= (w_nxt_state == ST_ISSUE);
            cpu_step_o <= (w_nxt_state == ST_STEP);
            error_o    <= (w_nxt_state == ST_ERROR);

            if (r_state == ST_ISSUE)
                r_cnt <= '0;
            else if (r_state == ST_WAIT && halt_i)
                r_cnt <= r_cnt + CNT_W'(1);

            // The write intent must survive the data-read transfer, so capture it at the fetch GAP.
            if (r_state == ST_GAP && r_op == OP_FETCH)
                r_wr_pend <= writeM_i;

            if (w_nxt_state == ST_ISSUE) begin
                case (w_nxt_op)
                    OP_FETCH: begin
                        address_o <= pc_i;
                        rwb_o     <= 1'b1;
                        selDest_o <= 1'b0;
                    end
                    OP_DREAD: begin
                        address_o <= addressM_i;
                        rwb_o     <= 1'b1;
                        selDest_o <= 1'b1;
                    end
                    default: begin
                        address_o <= addressM_i;
                        data_o    <= outM_i;
                        rwb_o     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer with a small spi_mem busy model that raises
// halt_i for a programmable number of cycles after each start pulse.
module tb_mem_sequencer;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        rwb;
        logic        sel;
        int          cyc;
    } xfer_t;

    logic        clk = 1'b0;
    logic        resetb;
    logic        run_i;
    logic [15:0] pc_i;
    logic [15:0] addressM_i;
    logic [15:0] outM_i;
    logic        readM_i;
    logic        writeM_i;
    logic        halt_i;
    logic        start_o;
    logic        rwb_o;
    logic        selDest_o;
    logic [15:0] address_o;
    logic [15:0] data_o;
    logic        cpu_step_o;
    logic        error_o;

    int    n_checks = 0;
    int    n_pass = 0;
    int    cyc = 0;
    int    halt_len = 0;
    int    halt_rem = 0;
    logic  prev_start = 1'b0;
    logic  prev_halt = 1'b0;
    int    fall_cyc = -100;
    int    spacing_viol = 0;
    int    hold_viol = 0;
    logic  holding = 1'b0;
    int    step_cnt = 0;
    int    step_cyc = -1;
    xfer_t cur;
    xfer_t log_q[$];

    always #5 clk = ~clk;

    mem_sequencer #(.TIMEOUT(63)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .run_i      (run_i),
        .pc_i       (pc_i),
        .addressM_i (addressM_i),
        .outM_i     (outM_i),
        .readM_i    (readM_i),
        .writeM_i   (writeM_i),
        .halt_i     (halt_i),
        .start_o    (start_o),
        .rwb_o      (rwb_o),
        .selDest_o  (selDest_o),
        .address_o  (address_o),
        .data_o     (data_o),
        .cpu_step_o (cpu_step_o),
        .error_o    (error_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // One cycle: update the busy model for this cycle, then sample and log the outputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (prev_start) halt_rem = halt_len;
        if (halt_rem > 0) begin
            halt_i = 1'b1;
            halt_rem--;
        end else begin
            halt_i = 1'b0;
        end
        if (prev_halt && !halt_i) fall_cyc = cyc;
        prev_halt  = halt_i;
        prev_start = start_o;
        if (start_o) begin
            if (cyc - fall_cyc < 2) spacing_viol++;
            cur = '{address_o, data_o, rwb_o, selDest_o, cyc};
            log_q.push_back(cur);
            holding = 1'b1;
        end else if (holding && (address_o !== cur.addr || data_o !== cur.data ||
                                 rwb_o !== cur.rwb || selDest_o !== cur.sel)) begin
            hold_viol++;
        end
        if (cpu_step_o) begin
            step_cnt++;
            step_cyc = cyc;
        end
    endtask

    function automatic xfer_t get_x(input int i);
        xfer_t none;
        none = '{16'h0, 16'h0, 1'b0, 1'b0, -1000};
        if (i < log_q.size()) return log_q[i];
        return none;
    endfunction

    // Runs one instruction; run_i drops drop_dly cycles after start number drop_k.
    task automatic run_instr(input logic [15:0] pc, input logic [15:0] am, input logic [15:0] om,
                             input logic rd, input logic wr, input int hlen,
                             input int drop_k, input int drop_dly);
        log_q.delete();
        step_cnt   = 0;
        step_cyc   = -1;
        pc_i       = pc;
        addressM_i = am;
        outM_i     = om;
        readM_i    = rd;
        writeM_i   = wr;
        halt_len   = hlen;
        run_i      = 1'b1;
        for (int i = 0; i < 300 && step_cnt == 0; i++) begin
            tick();
            if (run_i && log_q.size() >= drop_k && cyc >= log_q[drop_k-1].cyc + drop_dly)
                run_i = 1'b0;
        end
        repeat (6) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0;
        int t_err;
        resetb     = 1'b0;
        run_i      = 1'b0;
        pc_i       = 16'h0;
        addressM_i = 16'h0;
        outM_i     = 16'h0;
        readM_i    = 1'b0;
        writeM_i   = 1'b0;
        halt_i     = 1'b0;

        #12;
        check("rst_start",   32'(start_o),    32'd0);
        check("rst_rwb",     32'(rwb_o),      32'd1);
        check("rst_sel",     32'(selDest_o),  32'd0);
        check("rst_addr",    32'(address_o),  32'd0);
        check("rst_data",    32'(data_o),     32'd0);
        check("rst_step",    32'(cpu_step_o), 32'd0);
        check("rst_error",   32'(error_o),    32'd0);

        @(negedge clk);
        resetb = 1'b1;
        repeat (5) tick();
        check("idle_no_start", 32'(log_q.size()), 32'd0);

        // Fetch-only, 41 busy cycles.
        run_instr(16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 41, 1, 0);
        check("fetch_starts",  32'(log_q.size()), 32'd1);
        check("fetch_addr",    32'(get_x(0).addr), 32'h0010);
        check("fetch_rwb",     32'(get_x(0).rwb),  32'd1);
        check("fetch_sel",     32'(get_x(0).sel),  32'd0);
        check("fetch_steps",   32'(step_cnt),      32'd1);
        check("fetch_latency", 32'(step_cyc - get_x(0).cyc), 32'd44);
        check("fetch_idle",    32'(start_o),       32'd0);

        // Read-modify-write.
        run_instr(16'h0020, 16'h1234, 16'hBEEF, 1'b1, 1'b1, 5, 1, 0);
        check("rmw_starts",    32'(log_q.size()),  32'd3);
        check("rmw_f_addr",    32'(get_x(0).addr), 32'h0020);
        check("rmw_f_sel",     32'(get_x(0).sel),  32'd0);
        check("rmw_r_addr",    32'(get_x(1).addr), 32'h1234);
        check("rmw_r_rwb",     32'(get_x(1).rwb),  32'd1);
        check("rmw_r_sel",     32'(get_x(1).sel),  32'd1);
        check("rmw_w_addr",    32'(get_x(2).addr), 32'h1234);
        check("rmw_w_rwb",     32'(get_x(2).rwb),  32'd0);
        check("rmw_w_data",    32'(get_x(2).data), 32'hBEEF);
        check("rmw_gap_fr",    32'(get_x(1).cyc - get_x(0).cyc), 32'd8);
        check("rmw_gap_rw",    32'(get_x(2).cyc - get_x(1).cyc), 32'd8);
        check("rmw_steps",     32'(step_cnt),      32'd1);
        check("rmw_step_lat",  32'(step_cyc - get_x(2).cyc), 32'd8);
        check("spacing",       32'(spacing_viol),  32'd0);
        check("hold_stable",   32'(hold_viol),     32'd0);

        // Stop request during the data-read WAIT.
        run_instr(16'h0030, 16'h0044, 16'h5555, 1'b1, 1'b0, 4, 2, 2);
        check("stop_starts",   32'(log_q.size()),  32'd2);
        check("stop_r_addr",   32'(get_x(1).addr), 32'h0044);
        check("stop_r_sel",    32'(get_x(1).sel),  32'd1);
        check("stop_steps",    32'(step_cnt),      32'd1);
        check("stop_idle",     32'(start_o),       32'd0);

        // Reset pulse in the middle of a fetch WAIT.
        log_q.delete();
        step_cnt   = 0;
        pc_i       = 16'h0050;
        readM_i    = 1'b0;
        writeM_i   = 1'b0;
        halt_len   = 30;
        run_i      = 1'b1;
        for (int i = 0; i < 20 && log_q.size() == 0; i++) tick();
        check("mrst_pre_start", 32'(log_q.size()), 32'd1);
        repeat (5) tick();
        #2 resetb = 1'b0;
        #1;
        check("mrst_start",  32'(start_o),    32'd0);
        check("mrst_rwb",    32'(rwb_o),      32'd1);
        check("mrst_sel",    32'(selDest_o),  32'd0);
        check("mrst_addr",   32'(address_o),  32'd0);
        check("mrst_data",   32'(data_o),     32'd0);
        check("mrst_step",   32'(cpu_step_o), 32'd0);
        holding    = 1'b0;
        halt_rem   = 0;
        halt_i     = 1'b0;
        prev_start = 1'b0;
        prev_halt  = 1'b0;
        @(negedge clk);
        check("mrst_hold_idle", 32'(start_o), 32'd0);
        resetb = 1'b1;
        log_q.delete();
        tick();
        check("mrst_refetch",      32'(log_q.size()),  32'd1);
        check("mrst_refetch_addr", 32'(get_x(0).addr), 32'h0050);
        run_i = 1'b0;
        for (int i = 0; i < 100 && step_cnt == 0; i++) tick();
        check("mrst_steps", 32'(step_cnt), 32'd1);
        repeat (3) tick();

        // Timeout with halt_i stuck high.
        log_q.delete();
        step_cnt = 0;
        pc_i     = 16'h0060;
        halt_len = 1000;
        run_i    = 1'b1;
        for (int i = 0; i < 10 && log_q.size() == 0; i++) tick();
        t0 = get_x(0).cyc;
        t_err = -1;
        for (int i = 0; i < 200 && t_err < 0; i++) begin
            tick();
            if (error_o) t_err = cyc;
        end
        check("to_latency",  32'(t_err - t0),     32'd64);
        repeat (20) tick();
        check("to_starts",   32'(log_q.size()),   32'd1);
        check("to_steps",    32'(step_cnt),       32'd0);
        check("to_sticky",   32'(error_o),        32'd1);
        check("to_no_start", 32'(start_o),        32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 63, the maximum WAIT cycles allowed per transfer before error.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port resetb  input  1  asynchronous active-low reset.
REQ-004 SHALL have port run_i  input  1  permits starting a new instruction sequence.
REQ-005 SHALL have port pc_i  input  16  CPU program counter, the fetch address.
REQ-006 SHALL have port addressM_i  input  16  CPU data address.
REQ-007 SHALL have port outM_i  input  16  CPU write data.
REQ-008 SHALL have port readM_i  input  1  the decoded instruction reads M.
REQ-009 SHALL have port writeM_i  input  1  the decoded instruction writes M.
REQ-010 SHALL have port halt_i  input  1  busy flag from spi_mem.
REQ-011 SHALL have port start_o  output  1  transfer request to spi_mem.
REQ-012 SHALL have port rwb_o  output  1  1=read, 0=write.
REQ-013 SHALL have port selDest_o  output  1  0=instruction register, 1=inM register.
REQ-014 SHALL have port address_o  output  16  transfer address.
REQ-015 SHALL have port data_o  output  16  write data.
REQ-016 SHALL have port cpu_step_o  output  1  one-cycle CPU advance enable.
REQ-017 SHALL have port error_o  output  1  sticky timeout flag.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, GAP, STEP and ERROR, plus an operation register op_q in {FETCH, DREAD, DWRITE}.
REQ-019 SHALL go IDLE->ISSUE with op_q=FETCH when run_i=1, and hold IDLE otherwise.
REQ-020 SHALL, on ISSUE entry, register the transfer fields:
  - FETCH: address=pc_i, rwb=1, selDest=0.
  - DREAD: address=addressM_i, rwb=1, selDest=1.
  - DWRITE: address=addressM_i, data=outM_i, rwb=0.
REQ-021 SHALL hold address_o, data_o, rwb_o and selDest_o stable from ISSUE through the end of GAP.
REQ-022 SHALL assert start_o only in ISSUE, for exactly one cycle, then go to WAIT.
REQ-023 SHALL stay in WAIT while halt_i=1, and go to GAP on the first cycle with halt_i=0.
REQ-024 SHALL spend exactly one cycle in GAP, so that spi_mem has returned to idle before the next start.
REQ-025 SHALL choose the successor from GAP as follows:
  - After FETCH: ISSUE/DREAD if readM_i; else ISSUE/DWRITE if writeM_i; else STEP. readM_i and writeM_i are sampled in the GAP cycle.
  - After DREAD: ISSUE/DWRITE if writeM_i latched at the fetch GAP; else STEP.
  - After DWRITE: STEP.
REQ-026 SHALL, when readM_i and writeM_i are both 1, perform the read before the write (read-modify-write).
REQ-027 SHALL assert cpu_step_o for one cycle in STEP, then go to ISSUE/FETCH if run_i=1, else IDLE.
REQ-028 SHALL, when run_i falls mid-sequence, finish the sequence through STEP and then enter IDLE.
REQ-029 SHALL count WAIT cycles in a 6-bit counter cleared on ISSUE, and go to ERROR when the count reaches TIMEOUT with halt_i still 1.
REQ-030 SHALL make ERROR terminal: error_o=1, start_o=0 and cpu_step_o=0 until reset.
REQ-031 SHALL give a fetch-only instruction a latency of 1 (ISSUE) + N (WAIT) + 1 (GAP) + 1 (STEP) cycles, where N is the number of halt_i-high cycles.

Reset
REQ-032 SHALL, while resetb=0 and regardless of current state (including mid-transfer), immediately force:
  - state IDLE, op_q FETCH, counter 0;
  - start_o 0, rwb_o 1, selDest_o 0;
  - address_o 0, data_o 0;
  - cpu_step_o 0, error_o 0.
REQ-033 SHALL leave IDLE no earlier than the first rising clk edge after resetb rises.

Structure
REQ-034 SHALL take the state and op enums, and the default TIMEOUT constant, from shared package hack_mem_pkg.
REQ-035 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-036 SHALL cover a fetch-only instruction: run_i=1, pc_i=0x0010, readM=writeM=0, model holds halt_i high 41 cycles -> address_o=0x0010, rwb_o=1, selDest_o=0, one start_o pulse, cpu_step_o exactly 44 cycles after ISSUE.
REQ-037 SHALL cover a read-modify-write: readM=writeM=1, addressM_i=0x1234, outM_i=0xBEEF -> three start pulses in order FETCH, DREAD(sel=1), DWRITE(rwb=0, data_o=0xBEEF), then one cpu_step_o.
REQ-038 SHALL cover start spacing: start_o never asserted within 2 cycles of halt_i falling.
REQ-039 SHALL cover timeout: halt_i stuck at 1 -> error_o=1 after 63 WAIT cycles, with no further start_o or cpu_step_o.
REQ-040 SHALL cover stop request: run_i dropped during DREAD WAIT -> sequence completes with one cpu_step_o, then IDLE with start_o=0.
REQ-041 SHALL cover reset mid-transfer: resetb pulsed low during WAIT -> all outputs at reset values asynchronously, and a fresh FETCH begins after release.
